// File: rtl/window_sched.sv
// Sliding K x K window scheduler: gathers one pixel column per cycle from K row
// lanes and emits one window per column once K columns of a stripe are present.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start, lanes not ready
// FILL  | loading the first K-1 columns of a stripe, no output
// RUN   | each accepted column produces one window on m_axis
// DONE  | frame complete, waiting for the last window to drain
module window_sched #(
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int IMG_WIDTH   = 16,
    parameter int IMG_HEIGHT  = 16,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                                     clk,
    input  logic                                     rstn,
    input  logic                                     start,
    input  logic [KERNEL_SIZE*DATA_WIDTH-1:0]        lane_tdata,
    input  logic [KERNEL_SIZE-1:0]                   lane_tvalid,
    output logic [KERNEL_SIZE-1:0]                   lane_tready,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] m_axis_tdata,
    output logic                                     m_axis_tvalid,
    input  logic                                     m_axis_tready,
    output logic                                     m_axis_tlast,
    output logic                                     m_axis_tuser,
    output logic                                     busy,
    output logic                                     frame_done
);

    localparam int COL_W = KERNEL_SIZE * DATA_WIDTH;
    localparam int WIN_W = KERNEL_SIZE * COL_W;

    localparam logic [CNT_WIDTH-1:0] LAST_COL     = CNT_WIDTH'(IMG_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] FILL_END_COL = CNT_WIDTH'(KERNEL_SIZE - 2);
    localparam logic [CNT_WIDTH-1:0] FIRST_WIN_COL = CNT_WIDTH'(KERNEL_SIZE - 1);
    localparam logic [CNT_WIDTH-1:0] LAST_STRIPE  = CNT_WIDTH'(IMG_HEIGHT - KERNEL_SIZE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_WIDTH-1:0] col_cnt;
    logic [CNT_WIDTH-1:0] stripe_cnt;
    logic [WIN_W-1:0]     win;
    logic [WIN_W-1:0]     win_shift;
    logic                 out_free;
    logic                 accept_en;
    logic                 accept;
    logic                 col_last;
    logic                 frame_done_nxt;

    always_comb begin
        out_free       = !m_axis_tvalid || m_axis_tready;
        accept_en      = (state == FILL) || ((state == RUN) && out_free);
        accept         = accept_en && (&lane_tvalid);
        lane_tready    = {KERNEL_SIZE{accept}};
        col_last       = (col_cnt == LAST_COL);
        // Oldest column drops off the low end; the new column enters at the top.
        win_shift      = {lane_tdata, win[WIN_W-1:COL_W]};
        busy           = (state != IDLE);
        frame_done_nxt = 1'b0;
        state_nxt      = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = FILL;
            end
            FILL: begin
                if (accept && (col_cnt == FILL_END_COL)) state_nxt = RUN;
            end
            RUN: begin
                if (accept && col_last)
                    state_nxt = (stripe_cnt == LAST_STRIPE) ? DONE : FILL;
            end
            DONE: begin
                if (out_free) begin
                    frame_done_nxt = 1'b1;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            col_cnt       <= '0;
            stripe_cnt    <= '0;
            win           <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= frame_done_nxt;

            if ((state == IDLE) && start) begin
                col_cnt    <= '0;
                stripe_cnt <= '0;
            end else if (accept) begin
                win <= win_shift;
                if (col_last) begin
                    col_cnt    <= '0;
                    stripe_cnt <= stripe_cnt + CNT_WIDTH'(1);
                end else begin
                    col_cnt <= col_cnt + CNT_WIDTH'(1);
                end
            end

            // A reload in the same cycle as a handshake keeps tvalid high.
            if (accept && (state == RUN)) begin
                m_axis_tdata  <= win_shift;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= col_last;
                m_axis_tuser  <= (stripe_cnt == '0) && (col_cnt == FIRST_WIN_COL);
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_window_sched.sv
// Directed bench for window_sched with K=3, DW=8, a 5x4 image (two stripes of
// three windows each); pixel values follow pix() so every window is predictable.
module tb_window_sched;

    localparam int K  = 3;
    localparam int DW = 8;
    localparam int W  = 5;
    localparam int H  = 4;

    logic              clk = 1'b0;
    logic              rstn;
    logic              start;
    logic [K*DW-1:0]   lane_tdata;
    logic [K-1:0]      lane_tvalid;
    logic [K-1:0]      lane_tready;
    logic [K*K*DW-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic              m_axis_tuser;
    logic              busy;
    logic              frame_done;

    int n_checks = 0;
    int n_pass   = 0;
    int win_cnt  = 0;
    int base;

    window_sched #(
        .KERNEL_SIZE(K), .DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .CNT_WIDTH(8)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .lane_tdata(lane_tdata), .lane_tvalid(lane_tvalid), .lane_tready(lane_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rstn && m_axis_tvalid && m_axis_tready) win_cnt <= win_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] pix(input int s, input int c, input int r);
        return 8'(10 + c + 16 * r + 100 * s);
    endfunction

    function automatic logic [K*K*DW-1:0] exp_win(input int s, input int cnew);
        logic [K*K*DW-1:0] w;
        w = '0;
        for (int j = 0; j < K; j++)
            for (int r = 0; r < K; r++)
                w[(j*K+r)*DW +: DW] = pix(s, cnew - (K - 1) + j, r);
        return w;
    endfunction

    task automatic chk(input string tag, input logic [K*K*DW-1:0] obs,
                       input logic [K*K*DW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_col(input int s, input int c);
        for (int r = 0; r < K; r++) lane_tdata[r*DW +: DW] = pix(s, c, r);
    endtask

    task automatic push_col(input int s, input int c);
        int budget;
        budget = 20;
        set_col(s, c);
        lane_tvalid = '1;
        #1;
        while (lane_tready !== '1 && budget > 0) begin
            tick();
            budget--;
        end
        chk("accept_wait", budget > 0, 1'b1);
        tick();
        lane_tvalid = '0;
    endtask

    task automatic push_check(input int s, input int c);
        push_col(s, c);
        if (c >= K - 1) begin
            chk("win_tvalid", m_axis_tvalid, 1'b1);
            chk("win_tdata", m_axis_tdata, exp_win(s, c));
            chk("win_tlast", m_axis_tlast, c == W - 1);
            chk("win_tuser", m_axis_tuser, (s == 0) && (c == K - 1));
        end else begin
            chk("fill_tvalid", m_axis_tvalid, 1'b0);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1'b1);
    endtask

    task automatic finish_frame(input int first_win);
        lane_tvalid = '1;
        #1;
        chk("done_lane_tready", lane_tready, 3'b000);
        chk("done_busy", busy, 1'b1);
        lane_tvalid = '0;
        tick();
        chk("frame_done_pulse", frame_done, 1'b1);
        chk("done_tvalid", m_axis_tvalid, 1'b0);
        chk("done_idle", busy, 1'b0);
        tick();
        chk("frame_done_clear", frame_done, 1'b0);
        chk("window_count", win_cnt - first_win, 6);
    endtask

    initial begin
        rstn          = 1'b0;
        start         = 1'b0;
        lane_tdata    = '0;
        lane_tvalid   = '1;
        m_axis_tready = 1'b1;
        repeat (3) tick();
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_tdata", m_axis_tdata, '0);
        chk("rst_tlast", m_axis_tlast, 1'b0);
        chk("rst_tuser", m_axis_tuser, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_lane_tready", lane_tready, 3'b000);
        rstn        = 1'b1;
        tick();
        chk("idle_no_start", busy, 1'b0);
        chk("idle_lane_tready", lane_tready, 3'b000);
        lane_tvalid = '0;

        // Frame 1: free-running, with a start pulse landing mid-frame.
        base = win_cnt;
        do_start();
        for (int s = 0; s < 2; s++)
            for (int c = 0; c < W; c++) begin
                start = (s == 0 && c == 3);
                push_check(s, c);
                start = 1'b0;
            end
        finish_frame(base);

        // Frame 2: downstream stall and a partial lane valid.
        base = win_cnt;
        do_start();
        push_check(0, 0);
        push_check(0, 1);
        push_check(0, 2);
        chk("col0_row0", m_axis_tdata[7:0], 8'd10);
        chk("col1_row0", m_axis_tdata[31:24], 8'd11);
        chk("col2_row0", m_axis_tdata[55:48], 8'd12);
        m_axis_tready = 1'b0;
        set_col(0, 3);
        lane_tvalid = '1;
        repeat (5) begin
            tick();
            chk("stall_tvalid", m_axis_tvalid, 1'b1);
            chk("stall_tdata", m_axis_tdata, exp_win(0, 2));
            chk("stall_lane_tready", lane_tready, 3'b000);
        end
        m_axis_tready = 1'b1;
        push_check(0, 3);
        chk("no_bubble_count", win_cnt - base, 1);
        push_check(0, 4);
        push_check(1, 0);
        push_check(1, 1);
        push_check(1, 2);
        set_col(1, 3);
        lane_tvalid = 3'b101;
        repeat (4) begin
            tick();
            chk("partial_lane_tready", lane_tready, 3'b000);
        end
        chk("partial_drained", m_axis_tvalid, 1'b0);
        push_check(1, 3);
        push_check(1, 4);
        finish_frame(base);

        // Frame 3: reset during the second stripe with a window pending.
        base = win_cnt;
        do_start();
        for (int c = 0; c < W; c++) push_check(0, c);
        push_check(1, 0);
        push_check(1, 1);
        m_axis_tready = 1'b0;
        push_check(1, 2);
        rstn = 1'b0;
        tick();
        chk("midrst_tvalid", m_axis_tvalid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_tdata", m_axis_tdata, '0);
        rstn          = 1'b1;
        m_axis_tready = 1'b1;
        lane_tvalid   = '1;
        #1;
        chk("midrst_lane_tready", lane_tready, 3'b000);
        tick();
        chk("midrst_needs_start", busy, 1'b0);
        chk("midrst_discard", win_cnt - base, 3);
        lane_tvalid = '0;

        base = win_cnt;
        do_start();
        for (int s = 0; s < 2; s++)
            for (int c = 0; c < W; c++) push_check(s, c);
        finish_frame(base);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
